// File: rtl/mux_scan_ctrl.sv
// mux_scan_ctrl: scans a dual 4:1 mux channel by channel and hands the captured words to a consumer
module mux_scan_ctrl #(
    parameter int SETTLE = 2
) (
    input  logic       i_clk,
    input  logic       i_rst,
    input  logic       i_start,
    input  logic       i_cont,
    input  logic       i_1Y,
    input  logic       i_2Y,
    input  logic       i_ready,
    output logic       o_B,
    output logic       o_A,
    output logic       o_1G,
    output logic       o_2G,
    output logic [3:0] o_1D,
    output logic [3:0] o_2D,
    output logic       o_valid,
    output logic       o_busy
);
    typedef enum logic [1:0] {ST_IDLE, ST_SETTLE, ST_SAMPLE, ST_HOLD} state_t;
    localparam logic [3:0] CNT_LAST = 4'(SETTLE - 1);
    state_t state_q, state_d;
    logic [1:0] sel_q, sel_d;
    logic [3:0] cnt_q, cnt_d;
    logic [3:0] sh1_q, sh1_d, sh2_q, sh2_d;
    logic [3:0] d1_q, d1_d, d2_q, d2_d;
    logic valid_q, valid_d;
    logic busy_q, busy_d;
    logic [1:0] ba_q, ba_d;
    logic g_q, g_d;
    logic scanning_d;
    // next-state logic; outputs are derived from the next state so they come straight out of flops
    always_comb begin
        state_d = state_q;
        sel_d = sel_q;
        cnt_d = cnt_q;
        sh1_d = sh1_q;
        sh2_d = sh2_q;
        d1_d = d1_q;
        d2_d = d2_q;
        valid_d = valid_q;
        case (state_q)
            ST_IDLE: if (i_start) begin
                state_d = ST_SETTLE;
                sel_d = 2'd0;
                cnt_d = 4'd0;
            end
            ST_SETTLE: begin
                state_d = (cnt_q == CNT_LAST) ? ST_SAMPLE : ST_SETTLE;
                cnt_d = (cnt_q == CNT_LAST) ? cnt_q : cnt_q + 4'd1;
            end
            ST_SAMPLE: begin
                sh1_d[sel_q] = i_1Y;
                sh2_d[sel_q] = i_2Y;
                if (sel_q == 2'd3) begin
                    state_d = ST_HOLD;
                    d1_d = sh1_d;
                    d2_d = sh2_d;
                    valid_d = 1'b1;
                end else begin
                    state_d = ST_SETTLE;
                    sel_d = sel_q + 2'd1;
                    cnt_d = 4'd0;
                end
            end
            default: if (i_ready) begin
                valid_d = 1'b0;
                state_d = i_cont ? ST_SETTLE : ST_IDLE;
                sel_d = 2'd0;
                cnt_d = 4'd0;
            end
        endcase
        scanning_d = (state_d == ST_SETTLE) || (state_d == ST_SAMPLE);
        ba_d = scanning_d ? sel_d : 2'b00;
        g_d = !scanning_d;
        busy_d = (state_d != ST_IDLE);
    end
    // state and registered outputs, reset overrides everything including a scan in flight
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            state_q <= ST_IDLE;
            sel_q <= 2'd0;
            cnt_q <= 4'd0;
            sh1_q <= 4'h0;
            sh2_q <= 4'h0;
            d1_q <= 4'h0;
            d2_q <= 4'h0;
            valid_q <= 1'b0;
            busy_q <= 1'b0;
            ba_q <= 2'b00;
            g_q <= 1'b1;
        end else begin
            state_q <= state_d;
            sel_q <= sel_d;
            cnt_q <= cnt_d;
            sh1_q <= sh1_d;
            sh2_q <= sh2_d;
            d1_q <= d1_d;
            d2_q <= d2_d;
            valid_q <= valid_d;
            busy_q <= busy_d;
            ba_q <= ba_d;
            g_q <= g_d;
        end
    end
    assign {o_B, o_A} = ba_q;
    assign o_1G = g_q;
    assign o_2G = g_q;
    assign o_1D = d1_q;
    assign o_2D = d2_q;
    assign o_valid = valid_q;
    assign o_busy = busy_q;
endmodule

// File: tb/tb_mux_scan_ctrl.sv
// tb_mux_scan_ctrl: scoreboard bench for mux_scan_ctrl with a dual 4:1 mux model
module tb_mux_scan_ctrl;
    logic clk = 1'b0;
    logic rst = 1'b1;
    logic start = 1'b0, cont = 1'b0, ready = 1'b0;
    logic y1, y2, b, a, g1, g2, valid, busy;
    logic [3:0] d1, d2;
    logic [3:0] data1 = 4'h0, data2 = 4'h0;
    logic start1 = 1'b0, ready1 = 1'b0, cont1 = 1'b0;
    logic y1_1, y2_1, b1, a1, g1_1, g2_1, valid1, busy1;
    logic [3:0] d1_1, d2_1;
    logic [3:0] data1s = 4'h0, data2s = 4'h0;
    logic [7:0] exp_q[$];
    int n_cmp = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    assign y1 = g1 ? 1'b0 : data1[{b, a}];
    assign y2 = g2 ? 1'b0 : data2[{b, a}];
    assign y1_1 = g1_1 ? 1'b0 : data1s[{b1, a1}];
    assign y2_1 = g2_1 ? 1'b0 : data2s[{b1, a1}];

    mux_scan_ctrl #(.SETTLE(2)) dut (
        .i_clk(clk), .i_rst(rst), .i_start(start), .i_cont(cont),
        .i_1Y(y1), .i_2Y(y2), .i_ready(ready),
        .o_B(b), .o_A(a), .o_1G(g1), .o_2G(g2),
        .o_1D(d1), .o_2D(d2), .o_valid(valid), .o_busy(busy)
    );

    mux_scan_ctrl #(.SETTLE(1)) dut1 (
        .i_clk(clk), .i_rst(rst), .i_start(start1), .i_cont(cont1),
        .i_1Y(y1_1), .i_2Y(y2_1), .i_ready(ready1),
        .o_B(b1), .o_A(a1), .o_1G(g1_1), .o_2G(g2_1),
        .o_1D(d1_1), .o_2D(d2_1), .o_valid(valid1), .o_busy(busy1)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_scan(input logic [3:0] w1, input logic [3:0] w2);
        logic [1:0] es;
        logic [7:0] e;
        data1 = w1;
        data2 = w2;
        start = 1'b1;
        tick();
        start = 1'b0;
        exp_q.push_back({w1, w2});
        for (int c = 0; c < 12; c++) begin
            es = 2'(c / 3);
            n_cmp++;
            if ({b, a} !== es || g1 !== 1'b0 || g2 !== 1'b0 || valid !== 1'b0 || busy !== 1'b1) begin
                n_err++;
                $display("FAIL scan_seq c=%0d sel=%b g=%b%b valid=%b busy=%b, need sel=%b g=00 valid=0 busy=1",
                         c, {b, a}, g1, g2, valid, busy, es);
            end
            tick();
        end
        n_cmp++;
        if (valid !== 1'b1 || {b, a} !== 2'b00 || g1 !== 1'b1 || g2 !== 1'b1 || busy !== 1'b1) begin
            n_err++;
            $display("FAIL scan_done valid=%b sel=%b g=%b%b busy=%b, need 1 00 11 1", valid, {b, a}, g1, g2, busy);
        end
        e = (exp_q.size() != 0) ? exp_q.pop_front() : 8'hxx;
        n_cmp++;
        if ({d1, d2} !== e) begin
            n_err++;
            $display("FAIL scan_data got %h/%h need %h/%h", d1, d2, e[7:4], e[3:0]);
        end
    endtask

    task automatic test_reset();
        rst = 1'b1;
        tick();
        tick();
        rst = 1'b0;
        n_cmp++;
        if (valid !== 1'b0 || busy !== 1'b0 || {b, a} !== 2'b00 || g1 !== 1'b1 || g2 !== 1'b1) begin
            n_err++;
            $display("FAIL reset_ctrl valid=%b busy=%b sel=%b g=%b%b, need 0 0 00 11", valid, busy, {b, a}, g1, g2);
        end
        n_cmp++;
        if (d1 !== 4'h0 || d2 !== 4'h0 || valid1 !== 1'b0 || busy1 !== 1'b0) begin
            n_err++;
            $display("FAIL reset_data d=%h/%h valid1=%b busy1=%b, need 0/0 0 0", d1, d2, valid1, busy1);
        end
        tick();
        n_cmp++;
        if (busy !== 1'b0 || g1 !== 1'b1) begin
            n_err++;
            $display("FAIL reset_idle busy=%b g1=%b, need 0 1", busy, g1);
        end
    endtask

    task automatic test_single();
        ready = 1'b0;
        cont = 1'b0;
        do_scan(4'hA, 4'h6);
        ready = 1'b1;
        tick();
        ready = 1'b0;
        n_cmp++;
        if (valid !== 1'b0 || busy !== 1'b0 || d1 !== 4'hA || d2 !== 4'h6) begin
            n_err++;
            $display("FAIL single_hs valid=%b busy=%b d=%h/%h, need 0 0 a/6", valid, busy, d1, d2);
        end
    endtask

    task automatic test_backpressure();
        do_scan(4'h5, 4'h9);
        for (int i = 0; i < 5; i++) begin
            n_cmp++;
            if (valid !== 1'b1 || d1 !== 4'h5 || d2 !== 4'h9 || busy !== 1'b1) begin
                n_err++;
                $display("FAIL bp_hold i=%0d valid=%b d=%h/%h busy=%b, need 1 5/9 1", i, valid, d1, d2, busy);
            end
            tick();
        end
        ready = 1'b1;
        tick();
        ready = 1'b0;
        n_cmp++;
        if (valid !== 1'b0 || busy !== 1'b0 || g1 !== 1'b1 || d1 !== 4'h5) begin
            n_err++;
            $display("FAIL bp_release valid=%b busy=%b g1=%b d1=%h, need 0 0 1 5", valid, busy, g1, d1);
        end
    endtask

    task automatic test_continuous();
        int n;
        logic [7:0] e;
        cont = 1'b1;
        ready = 1'b1;
        do_scan(4'h3, 4'h5);
        data1 = 4'hC;
        exp_q.push_back({4'hC, 4'h5});
        tick();
        cont = 1'b0;
        n_cmp++;
        if (valid !== 1'b0 || busy !== 1'b1) begin
            n_err++;
            $display("FAIL cont_restart valid=%b busy=%b, need 0 1", valid, busy);
        end
        n = 1;
        while (valid !== 1'b1 && n < 40) begin
            tick();
            n++;
        end
        n_cmp++;
        if (n !== 13) begin
            n_err++;
            $display("FAIL cont_gap got %0d cycles need 13", n);
        end
        e = (exp_q.size() != 0) ? exp_q.pop_front() : 8'hxx;
        n_cmp++;
        if ({d1, d2} !== e) begin
            n_err++;
            $display("FAIL cont_data got %h/%h need %h/%h", d1, d2, e[7:4], e[3:0]);
        end
        tick();
        ready = 1'b0;
        n_cmp++;
        if (busy !== 1'b0 || valid !== 1'b0) begin
            n_err++;
            $display("FAIL cont_stop busy=%b valid=%b, need 0 0", busy, valid);
        end
    endtask

    task automatic test_ignored_start();
        int n;
        int nv;
        logic [7:0] e;
        data1 = 4'h7;
        data2 = 4'h2;
        start = 1'b1;
        tick();
        start = 1'b0;
        exp_q.push_back({4'h7, 4'h2});
        repeat (6) tick();
        n_cmp++;
        if ({b, a} !== 2'b10) begin
            n_err++;
            $display("FAIL ign_sel got %b need 10", {b, a});
        end
        start = 1'b1;
        tick();
        start = 1'b0;
        n = 7;
        while (valid !== 1'b1 && n < 40) begin
            tick();
            n++;
        end
        n_cmp++;
        if (n !== 12) begin
            n_err++;
            $display("FAIL ign_latency got %0d need 12", n);
        end
        e = (exp_q.size() != 0) ? exp_q.pop_front() : 8'hxx;
        n_cmp++;
        if ({d1, d2} !== e) begin
            n_err++;
            $display("FAIL ign_data got %h/%h need %h/%h", d1, d2, e[7:4], e[3:0]);
        end
        ready = 1'b1;
        tick();
        ready = 1'b0;
        nv = 0;
        repeat (20) begin
            if (valid !== 1'b0 || busy !== 1'b0) nv++;
            tick();
        end
        n_cmp++;
        if (nv !== 0) begin
            n_err++;
            $display("FAIL ign_extra got %0d active cycles need 0", nv);
        end
    endtask

    task automatic test_reset_mid();
        int nv;
        data1 = 4'h4;
        data2 = 4'hB;
        start = 1'b1;
        tick();
        start = 1'b0;
        exp_q.push_back({4'h4, 4'hB});
        repeat (5) tick();
        n_cmp++;
        if ({b, a} !== 2'b01) begin
            n_err++;
            $display("FAIL rm_sel got %b need 01", {b, a});
        end
        rst = 1'b1;
        tick();
        rst = 1'b0;
        exp_q.delete();
        n_cmp++;
        if (valid !== 1'b0 || busy !== 1'b0 || {b, a} !== 2'b00 || g1 !== 1'b1 || g2 !== 1'b1
            || d1 !== 4'h0 || d2 !== 4'h0) begin
            n_err++;
            $display("FAIL rm_state valid=%b busy=%b sel=%b g=%b%b d=%h/%h, need 0 0 00 11 0/0",
                     valid, busy, {b, a}, g1, g2, d1, d2);
        end
        nv = 0;
        repeat (15) begin
            if (valid !== 1'b0) nv++;
            tick();
        end
        n_cmp++;
        if (nv !== 0) begin
            n_err++;
            $display("FAIL rm_novalid got %0d valid cycles need 0", nv);
        end
        do_scan(4'hE, 4'h1);
        ready = 1'b1;
        tick();
        ready = 1'b0;
    endtask

    task automatic test_settle1();
        logic [1:0] es;
        logic [7:0] e;
        data1s = 4'h9;
        data2s = 4'h3;
        start1 = 1'b1;
        tick();
        start1 = 1'b0;
        exp_q.push_back({4'h9, 4'h3});
        for (int c = 0; c < 8; c++) begin
            es = 2'(c / 2);
            n_cmp++;
            if ({b1, a1} !== es || g1_1 !== 1'b0 || valid1 !== 1'b0) begin
                n_err++;
                $display("FAIL s1_seq c=%0d sel=%b g=%b valid=%b, need sel=%b g=0 valid=0", c, {b1, a1}, g1_1, valid1, es);
            end
            tick();
        end
        n_cmp++;
        if (valid1 !== 1'b1) begin
            n_err++;
            $display("FAIL s1_latency valid=%b need 1", valid1);
        end
        e = (exp_q.size() != 0) ? exp_q.pop_front() : 8'hxx;
        n_cmp++;
        if ({d1_1, d2_1} !== e) begin
            n_err++;
            $display("FAIL s1_data got %h/%h need %h/%h", d1_1, d2_1, e[7:4], e[3:0]);
        end
        ready1 = 1'b1;
        tick();
        ready1 = 1'b0;
        n_cmp++;
        if (busy1 !== 1'b0 || valid1 !== 1'b0) begin
            n_err++;
            $display("FAIL s1_idle busy=%b valid=%b need 0 0", busy1, valid1);
        end
    endtask

    initial begin
        test_reset();
        test_single();
        test_backpressure();
        test_continuous();
        test_ignored_start();
        test_reset_mid();
        test_settle1();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule

// File: doc/mux_scan_ctrl.md
MUX_SCAN_CTRL -- requirements
Module: mux_scan_ctrl

Interface
REQ-001 Parameter: SETTLE, default 2, select-to-sample settling cycles per channel; legal range 1..15.
REQ-002 i_clk  input  1  single clock; all state updates on rising edge.
REQ-003 i_rst  input  1  reset, synchronous, active-high.
REQ-004 i_start  input  1  scan request; sampled only in IDLE.
REQ-005 i_cont  input  1  continuous mode; when 1, a new scan restarts automatically after each handshake.
REQ-006 i_1Y  input  1  output of mux section 1 under control of this block.
REQ-007 i_2Y  input  1  output of mux section 2 under control of this block.
REQ-008 o_B  output  1  mux select MSB (channel index bit 1).
REQ-009 o_A  output  1  mux select LSB (channel index bit 0).
REQ-010 o_1G  output  1  section 1 strobe, active-low.
REQ-011 o_2G  output  1  section 2 strobe, active-low.
REQ-012 o_1D  output  4  captured section 1 word; bit k = i_1Y sampled while channel k selected.
REQ-013 o_2D  output  4  captured section 2 word; same mapping using i_2Y.
REQ-014 o_valid  output  1  o_1D/o_2D hold a completed scan not yet accepted.
REQ-015 i_ready  input  1  consumer accepts the word when o_valid and i_ready are both 1 at a rising edge.
REQ-016 o_busy  output  1  high in every state except IDLE.

Function
REQ-017 FSM states SHALL be IDLE, SETTLE, SAMPLE, HOLD; all outputs registered.
REQ-018 IDLE + i_start=1 -> SETTLE; channel index sel=0, settle counter=0.
REQ-019 SETTLE SHALL last exactly SETTLE cycles; the counter increments each cycle; when it reaches SETTLE-1 -> SAMPLE.
REQ-020 SAMPLE SHALL last 1 cycle; at its closing edge, bit sel of internal shadow registers is loaded with i_1Y/i_2Y.
REQ-021 SAMPLE with sel<3 -> SETTLE with sel+1 and counter cleared.
REQ-022 SAMPLE with sel=3 -> HOLD; at the same edge, o_1D/o_2D load the full 4-bit words (including the bit 3 just sampled) and o_valid goes 1.
REQ-023 Scan latency: o_valid first reads 1 exactly 4*(SETTLE+1) cycles after the edge that accepted i_start (12 cycles at SETTLE=2).
REQ-024 {o_B,o_A} SHALL equal sel in SETTLE and SAMPLE, and 2'b00 in IDLE and HOLD.
REQ-025 o_1G=o_2G=0 in SETTLE and SAMPLE; 1 in IDLE and HOLD.
REQ-026 HOLD: o_valid, o_1D and o_2D stay constant until handshake; handshake edge clears o_valid, then -> SETTLE (sel=0) if i_cont=1, else -> IDLE.
REQ-027 i_cont is sampled only at the handshake edge; changes at other times have no effect.
REQ-028 i_start outside IDLE SHALL be ignored; requests are not queued.
REQ-029 i_ready while o_valid=0 SHALL have no effect.
REQ-030 After handshake, o_1D/o_2D retain their last value until the next scan completes.
REQ-031 i_1Y/i_2Y SHALL be ignored outside SAMPLE.

Reset
REQ-032 i_rst=1 at an edge SHALL force IDLE, sel=0, counter=0, shadows=0, o_1D=o_2D=4'h0, o_valid=0, o_busy=0, o_B=o_A=0, o_1G=o_2G=1.
REQ-033 Reset SHALL take priority over every other input, including mid-scan and during HOLD; the partial scan is discarded and no o_valid is produced.
REQ-034 Rising edges with i_rst=0 after reset SHALL see IDLE behaviour.

Verification
REQ-035 Single scan, SETTLE=2, i_cont=0, bench models dual 4:1 mux with section 1 data 4'b1010 and section 2 data 4'b0110 -> o_valid rises 12 cycles after the start edge, o_1D=4'hA, o_2D=4'h6; {o_B,o_A} sequence is 00,01,10,11 with 3 cycles each; strobes low for exactly 12 cycles.
REQ-036 Backpressure: i_ready=0 for 5 cycles after o_valid -> o_valid and data held; i_ready=1 -> o_valid=0 next cycle, FSM reaches IDLE, o_busy=0.
REQ-037 Continuous: i_cont=1, i_ready=1, section 1 data changes from 4'h3 to 4'hC between scans -> back-to-back valid words 4'h3 then 4'hC, 13 cycles apart (12 scan + 1 HOLD).
REQ-038 Ignored start: pulse i_start during SETTLE of channel 2 -> exactly one o_valid results; the FSM then returns to IDLE.
REQ-039 Reset mid-scan: assert i_rst during SAMPLE of channel 1 -> next cycle all outputs at REQ-032 values; a fresh i_start then gives a correct word after 12 cycles.
REQ-040 SETTLE=1 build: single scan -> o_valid after 8 cycles; select changes every 2 cycles.
